agg_core: RTL and testbench

//   Neuron aggregation stage of the NN accelerator datapath.

---
 rtl/agg_pkg.sv | 20 ++
 rtl/agg_sat_add.sv | 25 ++
 rtl/agg_core.sv | 59 +++++
 tb/tb_agg_core.sv | 136 +++++++++++++
 4 files changed

// File: rtl/agg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agg_pkg : shared defaults and helpers for the aggregation stage      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package agg_pkg;

  localparam int AGG_WIDTH_DFLT  = 12;
  localparam int AGG_DEPTH_DFLT  = 4;
  localparam int ACT_THRESH_DFLT = 2048;

  localparam logic [AGG_WIDTH_DFLT-1:0] AGG_MAX = {AGG_WIDTH_DFLT{1'b1}};

  // A depth-1 window still needs a 1-bit counter so the compare is legal.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/agg_sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agg_sat_add : combinational adder, saturating when AGG_SAT_EN is set |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module agg_sat_add #(
  parameter int agg_width = 12
) (
  input  logic [agg_width-1:0] a,
  input  logic [agg_width-1:0] b,
  output logic [agg_width-1:0] sum
);

`ifdef AGG_SAT_EN
  logic [agg_width:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  // Once clamped, further unsigned adds stay clamped: saturation is sticky.
  assign sum  = full[agg_width] ? {agg_width{1'b1}} : full[agg_width-1:0];
`else
  assign sum = a + b;
`endif

endmodule
`default_nettype wire

// File: rtl/agg_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | agg_core : sums AGG_DEPTH inputs per window, registers sum and step  |
// | activation. Optional macro AGG_SAT_EN selects saturating adder.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module agg_core
  import agg_pkg::*;
#(
  parameter int agg_width  = AGG_WIDTH_DFLT,
  parameter int AGG_DEPTH  = AGG_DEPTH_DFLT,
  parameter int ACT_THRESH = ACT_THRESH_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [agg_width-1:0] agg_in,
  output logic [agg_width-1:0] agg_out2alu,
  output logic                 agg_out2act,
  output logic                 agg_out_acted
);

  localparam int CNT_W = cnt_width(AGG_DEPTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(AGG_DEPTH - 1);
  localparam logic [agg_width-1:0] THRESH   = agg_width'(ACT_THRESH);

  logic [agg_width-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic [agg_width-1:0] sum;

  agg_sat_add #(
    .agg_width(agg_width)
  ) u_add (
    .a  (acc),
    .b  (agg_in),
    .sum(sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      agg_out2alu   <= '0;
      agg_out2act   <= 1'b0;
      agg_out_acted <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      agg_out2alu   <= sum;
      agg_out2act   <= 1'b1;
      agg_out_acted <= (sum >= THRESH);
      acc           <= '0;
      cnt           <= '0;
    end else begin
      acc           <= sum;
      cnt           <= cnt + CNT_W'(1);
      agg_out2act   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agg_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_agg_core : directed self-checking bench for agg_core (12/4/2048)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_agg_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] agg_in;
  logic [11:0] agg_out2alu;
  logic        agg_out2act;
  logic        agg_out_acted;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int c1     = 0;
  int c2     = 0;

  agg_core #(
    .agg_width (12),
    .AGG_DEPTH (4),
    .ACT_THRESH(2048)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .agg_in       (agg_in),
    .agg_out2alu  (agg_out2alu),
    .agg_out2act  (agg_out2act),
    .agg_out_acted(agg_out_acted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input, let the edge sample it, then settle 1ns past the edge.
  task automatic drive(input int v);
    agg_in = 12'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int alu, input int act, input int acted);
    check({tag, "_alu"},   int'(agg_out2alu),   alu);
    check({tag, "_act"},   int'(agg_out2act),   act);
    check({tag, "_acted"}, int'(agg_out_acted), acted);
  endtask

  initial begin
    rst    = 1'b1;
    agg_in = 12'd7;
    #1;
    check_outs("rst_t0", 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outs("rst_hold", 0, 0, 0);
    end
    rst = 1'b0;

    // Basic window 1,3,2,1024 -> 1030
    drive(1);    check("w1_act0", int'(agg_out2act), 0);
    drive(3);    check("w1_act1", int'(agg_out2act), 0);
    drive(2);    check("w1_act2", int'(agg_out2act), 0);
    drive(1024); check_outs("w1", 1030, 1, 0);

    // Threshold just below: 2047 -> acted 0; outputs hold after pulse
    drive(2047); check_outs("w1_hold", 1030, 0, 0);
    drive(0);
    drive(0);    check_outs("w2_hold", 1030, 0, 0);
    drive(0);    check_outs("w2", 2047, 1, 0);

    // Threshold exact: 2000+48 = 2048 -> acted 1
    drive(2000);
    drive(48);
    drive(0);
    drive(0);    check_outs("w3", 2048, 1, 1);

    // Overflow window 2048,2048,1,0
    drive(2048);
    drive(2048);
    drive(1);
    drive(0);
`ifdef AGG_SAT_EN
    check_outs("w4_sat", 4095, 1, 1);
`else
    check_outs("w4_wrap", 1, 1, 0);
`endif

    // Mid-window reset: 5,6 then async reset between edges
    drive(5);
    drive(6);
    check("pre_rst_alu_nz", int'(agg_out2alu != 12'd0), 1);
    rst = 1'b1;
    #2;
    check_outs("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rst_edge", 0, 0, 0);
    rst = 1'b0;

    drive(1); check("w5_act0", int'(agg_out2act), 0);
    drive(1); check("w5_act1", int'(agg_out2act), 0);
    drive(1); check("w5_act2", int'(agg_out2act), 0);
    drive(1); check_outs("w5", 4, 1, 0);

    // Back-to-back windows (1,1,1,1) then (2,2,2,2)
    drive(1); check("w6_act0", int'(agg_out2act), 0);
    drive(1);
    drive(1);
    drive(1); check_outs("w6", 4, 1, 0);
    c1 = cyc;
    drive(2); check("w7_act0", int'(agg_out2act), 0);
    drive(2); check("w7_act1", int'(agg_out2act), 0);
    drive(2); check("w7_act2", int'(agg_out2act), 0);
    drive(2); check_outs("w7", 8, 1, 0);
    c2 = cyc;
    check("pulse_spacing", c2 - c1, 4);

    drive(0); check_outs("w7_hold", 8, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
